ppm_encoder: RTL and testbench

Generates a PPM pulse train from a set of channel values: the transmit-side counterpart of the team's PPM decoder.
- Each channel value 0..999 becomes a slot of 1000+value µs, measured between successive rising edges.
- Each frame ends with a sync slot longer than 5000 µs.
- Used as a loopback stimulus source and to drive downstream PPM consumers from on-chip control values.

---
 rtl/ppm_pkg.sv | 17 +
 rtl/ppm_us_tick.sv | 28 ++
 rtl/ppm_encoder.sv | 167 ++++++++++++++++
 tb/tb_ppm_encoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// Shared constants, channel type and state encoding for the PPM encoder.
package ppm_pkg;

    localparam int unsigned CH_W           = 12;
    localparam int unsigned CH_MAX         = 999;
    localparam int unsigned CH_OFFSET_US   = 1000;
    localparam int unsigned SYNC_DETECT_US = 5000;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHAN = 2'd1,
        SYNC = 2'd2
    } ppm_enc_state_t;

endpackage

// File: rtl/ppm_us_tick.sv
// Microsecond prescaler: one-cycle tick_c every TICKS_PER_US clocks; clr
// restarts the count so the first slot of a frame is a full tick long.
module ppm_us_tick #(
    parameter int unsigned TICKS_PER_US = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = !clr && (cnt_q == CNT_W'(TICKS_PER_US - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ppm_encoder.sv
// PPM pulse-train generator: NUM_CH channel slots plus a frame-padding sync slot.
// Define PPM_ENC_CLAMP_EN to clamp channel values above CH_MAX at snapshot.
module ppm_encoder
    import ppm_pkg::*;
#(
    parameter int unsigned NUM_CH       = 13,
    parameter int unsigned TICKS_PER_US = 1,
    parameter int unsigned PULSE_US     = 300,
    parameter int unsigned FRAME_US     = 32000,
    parameter int unsigned MIN_SYNC_US  = 6000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  ch_t  ch [NUM_CH],
    output logic ppm,
    output logic frame_start,
    output logic busy
);

    localparam int unsigned CHI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SLOT_W = 16;
    localparam int unsigned SUM_W  = 20;
    localparam int unsigned DIFF_W = SUM_W + 2;

    ppm_enc_state_t state_q, state_d;
    logic [CHI_W-1:0]  chi_q, chi_d, chi_nxt_c;
    logic [SLOT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic [SLOT_W-1:0] len_q, len_d, len0_c, len_nxt_c, sync_len_c;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic signed [DIFF_W-1:0] sync_diff_c;
    logic ppm_q, ppm_d, busy_q, busy_d, fs_q, fs_d;
    logic start_c, tick_c;
    ch_t  eff_ch_c [NUM_CH];
    ch_t  snap_q   [NUM_CH];

    ppm_us_tick #(
        .TICKS_PER_US(TICKS_PER_US)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == IDLE),
        .tick_c(tick_c)
    );

    // Value each channel contributes once snapshotted.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
`ifdef PPM_ENC_CLAMP_EN
            eff_ch_c[i] = (ch[i] > ch_t'(CH_MAX)) ? ch_t'(CH_MAX) : ch[i];
`else
            eff_ch_c[i] = ch[i];
`endif
        end
    end

    assign chi_nxt_c = chi_q + CHI_W'(1);
    assign len0_c    = SLOT_W'(CH_OFFSET_US) + SLOT_W'(eff_ch_c[0]);
    assign len_nxt_c = SLOT_W'(CH_OFFSET_US) + SLOT_W'(snap_q[chi_nxt_c]);

    // Sync pads the frame to FRAME_US but never drops below MIN_SYNC_US.
    assign sync_diff_c = $signed(DIFF_W'(FRAME_US)) - $signed(DIFF_W'(sum_q));
    assign sync_len_c  = (sync_diff_c < $signed(DIFF_W'(MIN_SYNC_US))) ?
                         SLOT_W'(MIN_SYNC_US) : SLOT_W'(sync_diff_c);

    always_comb begin
        state_d   = state_q;
        chi_d     = chi_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sum_d     = sum_q;
        ppm_d     = ppm_q;
        busy_d    = busy_q;
        fs_d      = 1'b0;
        start_c   = 1'b0;
        cnt_inc_c = cnt_q + SLOT_W'(1);

        unique case (state_q)
            IDLE: begin
                ppm_d   = 1'b1;
                busy_d  = 1'b0;
                start_c = en;
            end
            CHAN, SYNC: begin
                if (tick_c) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == SLOT_W'(PULSE_US)) begin
                        ppm_d = 1'b1;
                    end
                    if (cnt_inc_c == len_q) begin
                        cnt_d = '0;
                        ppm_d = 1'b0;
                        if (state_q == SYNC) begin
                            start_c = en;
                            if (!en) begin
                                state_d = IDLE;
                                ppm_d   = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end else if (chi_q == CHI_W'(NUM_CH - 1)) begin
                            state_d = SYNC;
                            len_d   = sync_len_c;
                        end else begin
                            chi_d = chi_nxt_c;
                            len_d = len_nxt_c;
                            sum_d = sum_q + SUM_W'(len_nxt_c);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame start: shared by IDLE launch and back-to-back continuation.
        if (start_c) begin
            state_d = CHAN;
            chi_d   = '0;
            cnt_d   = '0;
            len_d   = len0_c;
            sum_d   = SUM_W'(len0_c);
            ppm_d   = 1'b0;
            busy_d  = 1'b1;
            fs_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            chi_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            ppm_q   <= 1'b1;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            chi_q   <= chi_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            ppm_q   <= ppm_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                snap_q[i] <= '0;
            end
        end else if (start_c) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                snap_q[i] <= eff_ch_c[i];
            end
        end
    end

    assign ppm         = ppm_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ppm_encoder.sv
// Scoreboard bench for ppm_encoder: two instances (default and short FRAME_US),
// slot lengths and low-pulse widths checked against a queue of expected slots.
module tb_ppm_encoder;
    import ppm_pkg::*;

    localparam int unsigned NCH      = 13;
    localparam int          PULSE    = 300;
    localparam int          MIN_SYNC = 6000;
    localparam int          FRAME_A  = 32000;
    localparam int          FRAME_B  = 20000;

    logic clk = 1'b0;
    logic rst_a, rst_b, en_a, en_b;
    ch_t  ch_a [NCH];
    ch_t  ch_b [NCH];
    logic ppm_a, fs_a, busy_a, ppm_b, fs_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q0 [$];
    int exp_q1 [$];
    logic mon_en = 1'b0;
    logic ign     [2];
    logic prev_p  [2];
    logic prev_b  [2];
    logic active  [2];
    int   t_start [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppm_encoder #(
        .NUM_CH(NCH), .TICKS_PER_US(1), .PULSE_US(PULSE),
        .FRAME_US(FRAME_A), .MIN_SYNC_US(MIN_SYNC)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .ch(ch_a),
        .ppm(ppm_a), .frame_start(fs_a), .busy(busy_a)
    );

    ppm_encoder #(
        .NUM_CH(NCH), .TICKS_PER_US(1), .PULSE_US(PULSE),
        .FRAME_US(FRAME_B), .MIN_SYNC_US(MIN_SYNC)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .ch(ch_b),
        .ppm(ppm_b), .frame_start(fs_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int slot_len(input ch_t v);
`ifdef PPM_ENC_CLAMP_EN
        if (v > 999) return 1999;
`endif
        return 1000 + int'(v);
    endfunction

    task automatic push_exp(input int d, input int val);
        if (d == 0) exp_q0.push_back(val);
        else        exp_q1.push_back(val);
    endtask

    // Expected slots of one frame: each channel slot, then the sync slot.
    task automatic push_frame(input int d, input ch_t v [NCH], input int frame_us);
        int sum, s;
        sum = 0;
        for (int i = 0; i < int'(NCH); i++) begin
            sum += slot_len(v[i]);
            push_exp(d, slot_len(v[i]));
        end
        s = frame_us - sum;
        if (s < MIN_SYNC) s = MIN_SYNC;
        push_exp(d, s);
    endtask

    task automatic check_slot(input int d, input int dt);
        int n;
        n = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (n == 0) begin
            check_eq(d == 0 ? "a_sb_underflow" : "b_sb_underflow", dt, -1);
        end else if (d == 0) begin
            check_eq("a_slot_len", dt, exp_q0.pop_front());
        end else begin
            check_eq("b_slot_len", dt, exp_q1.pop_front());
        end
    endtask

    task automatic mon_step(input int d, input logic p, input logic b);
        int dt;
        dt = cyc - t_start[d];
        if (ign[d]) begin
            active[d] = 1'b0;
        end else if (prev_p[d] === 1'b1 && p === 1'b0) begin
            if (active[d]) check_slot(d, dt);
            t_start[d] = cyc;
            active[d]  = 1'b1;
        end else if (prev_p[d] === 1'b0 && p === 1'b1 && active[d]) begin
            check_eq(d == 0 ? "a_low_width" : "b_low_width", dt, PULSE);
        end else if (prev_b[d] === 1'b1 && b === 1'b0 && active[d]) begin
            check_slot(d, dt);
            active[d] = 1'b0;
        end
        prev_p[d] = p;
        prev_b[d] = b;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, ppm_a, busy_a);
            mon_step(1, ppm_b, busy_b);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input int d, input int budget, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (((d == 0) ? fs_a : fs_b) === 1'b1) got = 1'b1;
        end
        check_eq(tag, int'(got), 1);
        if (got) begin
            check_eq("fs_ppm_low", int'((d == 0) ? ppm_a : ppm_b), 0);
            check_eq("fs_busy", int'((d == 0) ? busy_a : busy_b), 1);
            @(posedge clk); #1;
            check_eq("fs_one_cycle", int'((d == 0) ? fs_a : fs_b), 0);
        end
    endtask

    task automatic wait_idle(input int d, input int budget, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (((d == 0) ? busy_a : busy_b) === 1'b0) got = 1'b1;
        end
        check_eq(tag, int'(got), 1);
    endtask

    task automatic drive_a();
        ch_t v [NCH];
        foreach (v[i]) v[i] = '0;
        ch_a = v;
        push_frame(0, v, FRAME_A);
        en_a = 1'b1;
        @(posedge clk); #1;
        check_eq("a_start_fs", int'(fs_a), 1);
        check_eq("a_start_ppm", int'(ppm_a), 0);
        check_eq("a_start_busy", int'(busy_a), 1);
        // Next frame's values change mid-frame; they must not leak into frame 1.
        wait_cycles(5000);
        foreach (v[i]) v[i] = ch_t'(999);
        ch_a = v;
        push_frame(0, v, FRAME_A);
        wait_fs(0, 33000, "a_fs_frame2");
        wait_cycles(6 * 1999 + 500);
        en_a = 1'b0;
        wait_idle(0, 30000, "a_idle_after_drop");
        wait_cycles(200);
        check_eq("a_idle_ppm", int'(ppm_a), 1);
        check_eq("a_idle_busy", int'(busy_a), 0);
        // Third frame is cut by reset inside slot 3's low pulse.
        foreach (v[i]) v[i] = ch_t'(500);
        ch_a = v;
        push_frame(0, v, FRAME_A);
        en_a = 1'b1;
        wait_fs(0, 10, "a_fs_frame3");
        wait_cycles(3 * 1500 + 100);
        check_eq("a_pre_rst_ppm", int'(ppm_a), 0);
        ign[0] = 1'b1;
        #1 rst_a = 1'b1;
        #1;
        check_eq("a_rst_async_ppm", int'(ppm_a), 1);
        check_eq("a_rst_async_busy", int'(busy_a), 0);
        check_eq("a_q_left_at_rst", exp_q0.size(), 11);
        exp_q0.delete();
        en_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b0;
        wait_cycles(5);
        check_eq("a_post_rst_ppm", int'(ppm_a), 1);
        check_eq("a_post_rst_busy", int'(busy_a), 0);
        ign[0] = 1'b0;
    endtask

    task automatic drive_b();
        ch_t v [NCH];
        foreach (v[i]) v[i] = ch_t'(999);
        ch_b = v;
        push_frame(1, v, FRAME_B);
        en_b = 1'b1;
        @(posedge clk); #1;
        check_eq("b_start_fs", int'(fs_b), 1);
        wait_cycles(3000);
        foreach (v[i]) v[i] = ch_t'($urandom_range(0, 499));
        v[0] = ch_t'(4000);
        ch_b = v;
        push_frame(1, v, FRAME_B);
        wait_fs(1, 33000, "b_fs_frame2");
        // ch[4] changes mid-frame; visible only from the next frame.
        wait_cycles(1000);
        v[4] = ch_t'(999);
        ch_b = v;
        push_frame(1, v, FRAME_B);
        wait_fs(1, 36000, "b_fs_frame3");
        wait_cycles(2000);
        en_b = 1'b0;
        wait_idle(1, 30000, "b_idle_after_drop");
        wait_cycles(50);
        check_eq("b_idle_ppm", int'(ppm_b), 1);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        foreach (ch_a[i]) ch_a[i] = '0;
        foreach (ch_b[i]) ch_b[i] = '0;
        for (int d = 0; d < 2; d++) begin
            ign[d] = 1'b0; prev_p[d] = 1'b1; prev_b[d] = 1'b0;
            active[d] = 1'b0; t_start[d] = 0;
        end
        wait_cycles(3);
        check_eq("a_rst_ppm", int'(ppm_a), 1);
        check_eq("a_rst_busy", int'(busy_a), 0);
        check_eq("a_rst_fs", int'(fs_a), 0);
        check_eq("b_rst_ppm", int'(ppm_b), 1);
        check_eq("b_rst_busy", int'(busy_b), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        wait_cycles(2);
        check_eq("a_idle_no_en_ppm", int'(ppm_a), 1);
        check_eq("b_idle_no_en_busy", int'(busy_b), 0);
        mon_en = 1'b1;
        fork
            drive_a();
            drive_b();
        join
        check_eq("b_q_left_end", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
